pipe_ctrl_unit: RTL and testbench

Pipelined main control for the 5-stage MIPS core. It decodes the ID-stage opcode into a 14-bit control bundle and carries that bundle, with the destination register, through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards, inserts bubbles, squashes the ID instruction on an EX redirect, and keeps a saturating illegal-opcode count. It supersedes the combinational single-stage decoder and adds BNE, ORI and illegal-opcode handling.

---
 rtl/mips_ctrl_pkg.sv | 66 ++++++
 rtl/ctrl_decode.sv | 68 ++++++
 rtl/pipe_ctrl_unit.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS main-control path: opcodes, bundle layout
// and field encodings used by both the pipelined and single-cycle cores.
package mips_ctrl_pkg;

    localparam int CTRL_W = 14;

    // Bit positions inside the 14-bit control bundle (MSB first)
    localparam int BIT_REG_DST_HI    = 13;
    localparam int BIT_REG_DST_LO    = 12;
    localparam int BIT_ALU_SRC       = 11;
    localparam int BIT_ALU_OP_HI     = 10;
    localparam int BIT_ALU_OP_LO     = 9;
    localparam int BIT_SIGN_EXT      = 8;
    localparam int BIT_BRANCH        = 7;
    localparam int BIT_BRANCH_NE     = 6;
    localparam int BIT_JUMP          = 5;
    localparam int BIT_MEM_READ      = 4;
    localparam int BIT_MEM_WRITE     = 3;
    localparam int BIT_MEM_TO_REG_HI = 2;
    localparam int BIT_MEM_TO_REG_LO = 1;
    localparam int BIT_REG_WRITE     = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_LOGIC = 2'b11;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
    localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

    // Field order matches the bit positions above, so a cast to logic [13:0] is exact
    typedef struct packed {
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       sign_ext;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // Opcodes whose rt field is a source operand (rather than a destination)
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the 14-bit control bundle and flags
// unknown opcodes. Unknown opcodes decode to an all-zero bubble.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]        opcode_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o
);

    ctrl_t ctrl_d;

    always_comb begin
        ctrl_d          = '0;
        ctrl_d.sign_ext = 1'b1;
        illegal_o       = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_d.reg_dst   = REG_DST_RD;
                ctrl_d.alu_op    = ALU_OP_FUNCT;
                ctrl_d.reg_write = 1'b1;
            end
            OP_ADDI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_OP_ADD;
                ctrl_d.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_op    = ALU_OP_LOGIC;
                ctrl_d.sign_ext  = 1'b0;
                ctrl_d.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = MEM_TO_REG_MEM;
                ctrl_d.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = ALU_OP_SUB;
            end
            OP_BNE: begin
                ctrl_d.branch    = 1'b1;
                ctrl_d.branch_ne = 1'b1;
                ctrl_d.alu_op    = ALU_OP_SUB;
            end
            OP_JAL: begin
                ctrl_d.jump       = 1'b1;
                ctrl_d.reg_dst    = REG_DST_RA;
                ctrl_d.mem_to_reg = MEM_TO_REG_PC;
                ctrl_d.reg_write  = 1'b1;
            end
            default: begin
                ctrl_d    = '0;
                illegal_o = 1'b1;
            end
        endcase
    end

    assign ctrl_o = ctrl_d;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control: decodes ID, carries control bundles and destination
// indices through ID/EX, EX/MEM and MEM/WB, handles load-use stalls and redirects.
module pipe_ctrl_unit
    import mips_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit HAZARD_EN  = 1'b1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [5:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    output logic                  stall,
    output logic                  flush_ifid,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [CTRL_W-1:0]     mem_ctrl,
    output logic [CTRL_W-1:0]     wb_ctrl,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  illegal,
    output logic [ERR_CNT_W-1:0]  illegal_cnt
);

    localparam logic [REG_ADDR_W-1:0] RA_IDX = REG_ADDR_W'(31);

    logic [CTRL_W-1:0]     dec_ctrl;
    logic                  dec_illegal;
    logic [REG_ADDR_W-1:0] dec_dest;
    logic                  load_use;
    logic                  advance;

    logic [CTRL_W-1:0]     ex_ctrl_q,  ex_ctrl_d;
    logic [CTRL_W-1:0]     mem_ctrl_q;
    logic [CTRL_W-1:0]     wb_ctrl_q;
    logic [REG_ADDR_W-1:0] ex_dest_q,  ex_dest_d;
    logic [REG_ADDR_W-1:0] mem_dest_q;
    logic [REG_ADDR_W-1:0] wb_dest_q;
    logic                  illegal_q,  illegal_d;
    logic [ERR_CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;

    ctrl_decode u_decode (
        .opcode_i  (id_opcode),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        dec_dest = '0;
        if (dec_ctrl[BIT_REG_WRITE]) begin
            case (dec_ctrl[BIT_REG_DST_HI:BIT_REG_DST_LO])
                REG_DST_RT: dec_dest = id_rt;
                REG_DST_RD: dec_dest = id_rd;
                REG_DST_RA: dec_dest = RA_IDX;
                default:    dec_dest = '0;
            endcase
        end
    end

    // rt only counts as a hazard source for opcodes that actually read it
    always_comb begin
        load_use = 1'b0;
        if (HAZARD_EN && id_valid && ex_ctrl_q[BIT_MEM_READ] && (ex_dest_q != '0)) begin
            load_use = (ex_dest_q == id_rs) ||
                       ((ex_dest_q == id_rt) && reads_rt(id_opcode));
        end
    end

    assign stall      = load_use && !ex_redirect;
    assign flush_ifid = ex_redirect;
    assign advance    = id_valid && !stall && !ex_redirect;

    always_comb begin
        ex_ctrl_d     = '0;
        ex_dest_d     = '0;
        illegal_d     = 1'b0;
        illegal_cnt_d = illegal_cnt_q;
        if (advance) begin
            ex_ctrl_d = dec_ctrl;
            ex_dest_d = dec_dest;
            illegal_d = dec_illegal;
            if (dec_illegal && (illegal_cnt_q != '1)) begin
                illegal_cnt_d = illegal_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q     <= '0;
            mem_ctrl_q    <= '0;
            wb_ctrl_q     <= '0;
            ex_dest_q     <= '0;
            mem_dest_q    <= '0;
            wb_dest_q     <= '0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            ex_ctrl_q     <= ex_ctrl_d;
            ex_dest_q     <= ex_dest_d;
            mem_ctrl_q    <= ex_ctrl_q;
            mem_dest_q    <= ex_dest_q;
            wb_ctrl_q     <= mem_ctrl_q;
            wb_dest_q     <= mem_dest_q;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign ex_ctrl     = ex_ctrl_q;
    assign mem_ctrl    = mem_ctrl_q;
    assign wb_ctrl     = wb_ctrl_q;
    assign ex_dest     = ex_dest_q;
    assign mem_dest    = mem_dest_q;
    assign wb_dest     = wb_dest_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with load-use stalling,
// one without, both fed the same ID stream.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_redirect;

    logic        stall, flush_ifid, illegal;
    logic [13:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_dest, mem_dest, wb_dest;
    logic [7:0]  illegal_cnt;

    logic        nh_stall, nh_flush, nh_illegal;
    logic [13:0] nh_ex_ctrl, nh_mem_ctrl, nh_wb_ctrl;
    logic [4:0]  nh_ex_dest, nh_mem_dest, nh_wb_dest;
    logic [7:0]  nh_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .HAZARD_EN(1'b1), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(stall), .flush_ifid(flush_ifid),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    pipe_ctrl_unit #(.REG_ADDR_W(5), .HAZARD_EN(1'b0), .ERR_CNT_W(8)) dut_nh (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(nh_stall), .flush_ifid(nh_flush),
        .ex_ctrl(nh_ex_ctrl), .mem_ctrl(nh_mem_ctrl), .wb_ctrl(nh_wb_ctrl),
        .ex_dest(nh_ex_dest), .mem_dest(nh_mem_dest), .wb_dest(nh_wb_dest),
        .illegal(nh_illegal), .illegal_cnt(nh_cnt)
    );

    // Hand-written expected bundles: reg_dst_alusrc_aluop_sext_br_bne_j_mr_mw_m2r_rw
    localparam logic [13:0] B_R    = 14'b01_0_10_1_0_0_0_0_0_00_1;
    localparam logic [13:0] B_ADDI = 14'b00_1_00_1_0_0_0_0_0_00_1;
    localparam logic [13:0] B_ANDI = 14'b00_1_11_0_0_0_0_0_0_00_1;
    localparam logic [13:0] B_ORI  = 14'b00_1_11_0_0_0_0_0_0_00_1;
    localparam logic [13:0] B_LW   = 14'b00_1_00_1_0_0_0_1_0_01_1;
    localparam logic [13:0] B_SW   = 14'b00_1_00_1_0_0_0_0_1_00_0;
    localparam logic [13:0] B_BEQ  = 14'b00_0_01_1_1_0_0_0_0_00_0;
    localparam logic [13:0] B_BNE  = 14'b00_0_01_1_1_1_0_0_0_00_0;
    localparam logic [13:0] B_JAL  = 14'b10_0_00_1_0_0_1_0_0_10_1;

    logic [5:0]  sw_op   [9];
    logic [13:0] sw_exp  [9];
    logic [4:0]  sw_dest [9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
    endtask

    initial begin
        sw_op   = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h03};
        sw_exp  = '{B_R, B_ADDI, B_ANDI, B_ORI, B_LW, B_SW, B_BEQ, B_BNE, B_JAL};
        // R uses rd=20+i; I-type writers use rt=10+i; SW/branches write nothing; JAL writes 31
        sw_dest = '{5'd20, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd0, 5'd0, 5'd31};

        rst_n       = 1'b0;
        ex_redirect = 1'b0;
        set_id(1'b0, 6'h00, 5'd0, 5'd0, 5'd0);
        tick();
        chk("reset_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("reset_wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);
        chk("reset_cnt", 32'(illegal_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Opcode sweep with no hazards; each bundle checked in EX, MEM and WB
        for (int i = 0; i < 9; i++) begin
            set_id(1'b1, sw_op[i], 5'd1, 5'(10 + i), 5'(20 + i));
            #1;
            chk($sformatf("sweep%0d_stall", i), 32'(stall), 32'd0);
            tick();
            chk($sformatf("sweep%0d_ex_ctrl", i), 32'(ex_ctrl), 32'(sw_exp[i]));
            chk($sformatf("sweep%0d_ex_dest", i), 32'(ex_dest), 32'(sw_dest[i]));
            if (i >= 1) chk($sformatf("sweep%0d_mem_ctrl", i), 32'(mem_ctrl), 32'(sw_exp[i-1]));
            if (i >= 2) chk($sformatf("sweep%0d_wb_ctrl", i), 32'(wb_ctrl), 32'(sw_exp[i-2]));
            if (i >= 2) chk($sformatf("sweep%0d_wb_dest", i), 32'(wb_dest), 32'(sw_dest[i-2]));
        end
        set_id(1'b0, 6'h00, 5'd0, 5'd0, 5'd0);
        tick();
        chk("invalid_bubble", 32'(ex_ctrl), 32'd0);
        tick();

        // Load-use: LW rt=5 then ADD rs=5
        set_id(1'b1, 6'h23, 5'd1, 5'd5, 5'd0);
        tick();
        chk("lu_lw_ex", 32'(ex_ctrl), 32'(B_LW));
        set_id(1'b1, 6'h00, 5'd5, 5'd2, 5'd6);
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_nh_stall", 32'(nh_stall), 32'd0);
        tick();
        chk("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
        chk("lu_bubble_dest", 32'(ex_dest), 32'd0);
        chk("lu_mem_lw", 32'(mem_ctrl), 32'(B_LW));
        chk("lu_nh_add_ex", 32'(nh_ex_ctrl), 32'(B_R));
        chk("lu_stall_drop", 32'(stall), 32'd0);
        tick();
        chk("lu_add_ex", 32'(ex_ctrl), 32'(B_R));
        chk("lu_add_dest", 32'(ex_dest), 32'd6);
        chk("lu_wb_lw", 32'(wb_ctrl), 32'(B_LW));

        // SW rt=5 after LW stalls
        set_id(1'b1, 6'h23, 5'd1, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'h2B, 5'd1, 5'd5, 5'd0);
        #1;
        chk("sw_stall", 32'(stall), 32'd1);
        tick();
        chk("sw_bubble", 32'(ex_ctrl), 32'd0);
        tick();
        chk("sw_ex", 32'(ex_ctrl), 32'(B_SW));

        // ADDI rt=5 after LW: rt is a destination, no stall
        set_id(1'b1, 6'h23, 5'd1, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'h08, 5'd1, 5'd5, 5'd0);
        #1;
        chk("addi_nostall", 32'(stall), 32'd0);
        tick();
        chk("addi_ex", 32'(ex_ctrl), 32'(B_ADDI));
        chk("addi_dest", 32'(ex_dest), 32'd5);

        // Redirect during a load-use condition
        set_id(1'b1, 6'h23, 5'd1, 5'd5, 5'd0);
        tick();
        set_id(1'b1, 6'h00, 5'd5, 5'd2, 5'd6);
        ex_redirect = 1'b1;
        #1;
        chk("redir_stall", 32'(stall), 32'd0);
        chk("redir_flush", 32'(flush_ifid), 32'd1);
        tick();
        ex_redirect = 1'b0;
        chk("redir_bubble", 32'(ex_ctrl), 32'd0);
        chk("redir_flush_off", 32'(flush_ifid), 32'd0);

        // Illegal opcode 0x3F
        set_id(1'b1, 6'h3F, 5'd1, 5'd2, 5'd3);
        tick();
        chk("ill_bubble", 32'(ex_ctrl), 32'd0);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_cnt1", 32'(illegal_cnt), 32'd1);
        set_id(1'b0, 6'h00, 5'd0, 5'd0, 5'd0);
        tick();
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        chk("ill_cnt_hold", 32'(illegal_cnt), 32'd1);

        // A squashed illegal is not counted
        set_id(1'b1, 6'h3F, 5'd1, 5'd2, 5'd3);
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        chk("ill_squash_pulse", 32'(illegal), 32'd0);
        chk("ill_squash_cnt", 32'(illegal_cnt), 32'd1);

        // A stalled illegal is counted once, when it advances
        set_id(1'b1, 6'h23, 5'd1, 5'd7, 5'd0);
        tick();
        set_id(1'b1, 6'h3F, 5'd7, 5'd2, 5'd3);
        #1;
        chk("ill_stall", 32'(stall), 32'd1);
        tick();
        chk("ill_stalled_cnt", 32'(illegal_cnt), 32'd1);
        tick();
        chk("ill_adv_cnt", 32'(illegal_cnt), 32'd2);

        // Saturation: 300 more illegals
        for (int i = 0; i < 300; i++) tick();
        chk("ill_sat_cnt", 32'(illegal_cnt), 32'd255);
        chk("ill_sat_pulse", 32'(illegal), 32'd1);

        // Asynchronous reset mid-stream
        set_id(1'b1, 6'h00, 5'd1, 5'd2, 5'd3);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_ex", 32'(ex_ctrl), 32'd0);
        chk("areset_mem", 32'(mem_ctrl), 32'd0);
        chk("areset_dest", 32'(ex_dest), 32'd0);
        chk("areset_cnt", 32'(illegal_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        set_id(1'b1, 6'h03, 5'd1, 5'd2, 5'd3);
        tick();
        chk("post_reset_ex", 32'(ex_ctrl), 32'(B_JAL));
        chk("post_reset_dest", 32'(ex_dest), 32'd31);
        chk("post_reset_mem", 32'(mem_ctrl), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
